// File: rtl/dot_acc_uint4_pkg.sv
// Shared definitions for the PIM integer-arithmetic dot-product stage:
// FSM encodings and the product width delivered by mul_uint4.
package dot_acc_uint4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dot_state_t;

  localparam int PROD_W = 4;

endpackage

// File: rtl/dot_acc_uint4_mul.sv
// 4x4 unsigned multiplier returning only the low 4 bits of the product.
module mul_uint4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] P
);

  // Evaluated in a 4-bit context, so the product wraps modulo 16.
  assign P = A * B;

endmodule

// File: rtl/dot_acc_uint4.sv
// Streaming dot product: VEC_LEN truncated 4-bit products accumulated
// modulo 2^ACC_W with a sticky carry-out flag, handed off over valid/ready.
//
// state | meaning
// IDLE  | waiting for the first operand pair of a vector
// RUN   | accepting pairs / draining the product stage
// DONE  | result presented on out_sum/out_ovf, input stalled
module dot_acc_uint4
  import dot_acc_uint4_pkg::*;
#(
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);

  dot_state_t         r_state;
  dot_state_t         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic               r_p_valid;
  logic [3:0]         r_a;
  logic [3:0]         r_b;

  logic [PROD_W-1:0]  w_prod;
  logic [ACC_W:0]     w_sum;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_last;

  mul_uint4 u_mul (
    .A (r_a),
    .B (r_b),
    .P (w_prod)
  );

  assign in_ready  = (r_state != ST_DONE) && (r_cnt < CNT_W'(VEC_LEN));
  assign out_valid = (r_state == ST_DONE);
  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;

  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;
  assign w_last   = r_p_valid && (r_cnt == CNT_W'(VEC_LEN));
  // The extra top bit of the sum is the carry out of the accumulator.
  assign w_sum    = {1'b0, r_acc} + {{(ACC_W - PROD_W + 1){1'b0}}, w_prod};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_in_hs)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)   w_state_nxt = ST_DONE;
      ST_DONE: if (w_out_hs) w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_p_valid <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_p_valid <= w_in_hs;
      if (w_in_hs) begin
        r_a <= in_a;
        r_b <= in_b;
      end
      if (w_out_hs) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_in_hs) r_cnt <= r_cnt + 1'b1;
        if (r_p_valid) begin
          r_acc <= w_sum[ACC_W-1:0];
          if (w_sum[ACC_W]) r_ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_acc_uint4.sv
// Randomized and directed bench for dot_acc_uint4 (VEC_LEN=4) with an
// 8-bit and a 4-bit accumulator build sharing one input stream.
module tb_dot_acc_uint4;

  localparam int VEC_LEN = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_ready;

  logic       in_ready8, out_valid8, out_ovf8;
  logic [7:0] out_sum8;
  logic       in_ready4, out_valid4, out_ovf4;
  logic [3:0] out_sum4;

  int n_chk  = 0;
  int n_pass = 0;

  dot_acc_uint4 #(.VEC_LEN(VEC_LEN), .ACC_W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .out_sum   (out_sum8),
    .out_ovf   (out_ovf8)
  );

  dot_acc_uint4 #(.VEC_LEN(VEC_LEN), .ACC_W(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_sum   (out_sum4),
    .out_ovf   (out_ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: counts accepted pairs, sums truncated products as a
  // plain integer, and tracks when the result is due (2 cycles after the
  // last handshake) and when it is consumed.
  int m_n    = 0;
  int m_tot  = 0;
  int m_lat  = 0;
  bit m_done = 1'b0;

  always @(negedge clk) begin
    bit exp_ready;
    if (!rst_n) begin
      m_n = 0; m_tot = 0; m_lat = 0; m_done = 1'b0;
      chk("rst_out_valid8", 32'(out_valid8), 0);
      chk("rst_out_sum8",   32'(out_sum8),   0);
      chk("rst_out_ovf4",   32'(out_ovf4),   0);
      chk("rst_out_sum4",   32'(out_sum4),   0);
    end else begin
      if (m_lat > 0) begin
        m_lat--;
        if (m_lat == 0) m_done = 1'b1;
      end
      exp_ready = !m_done && (m_n < VEC_LEN);
      chk("out_valid8", 32'(out_valid8), 32'(m_done));
      chk("out_valid4", 32'(out_valid4), 32'(m_done));
      chk("in_ready8",  32'(in_ready8),  32'(exp_ready));
      chk("in_ready4",  32'(in_ready4),  32'(exp_ready));
      if (m_done) begin
        chk("out_sum8", 32'(out_sum8), m_tot % 256);
        chk("out_ovf8", 32'(out_ovf8), 32'(m_tot >= 256));
        chk("out_sum4", 32'(out_sum4), m_tot % 16);
        chk("out_ovf4", 32'(out_ovf4), 32'(m_tot >= 16));
        if (out_ready) begin
          m_done = 1'b0; m_n = 0; m_tot = 0;
        end
      end
      if (in_valid && exp_ready) begin
        m_n++;
        m_tot += (int'(in_a) * int'(in_b)) % 16;
        if (m_n == VEC_LEN) m_lat = 2;
      end
    end
  end

  task automatic drive(input bit v, input int a, input int b, input bit r);
    in_valid  = v;
    in_a      = 4'(a);
    in_b      = 4'(b);
    out_ready = r;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 1);

    // Basic, with the result then held under back-pressure while new
    // operands are offered, then released into a (1,1) vector.
    for (int i = 0; i < 4; i++) drive(1, 3, 5, 0);
    for (int i = 0; i < 8; i++) drive(1, 1, 1, 0);
    for (int i = 0; i < 8; i++) drive(1, 1, 1, 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);

    // Truncation: 49 mod 16 = 1 per element.
    for (int i = 0; i < 4; i++) drive(1, 7, 7, 1);
    repeat (4) drive(0, 0, 0, 1);

    // Gapped input.
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 5, 1);
      drive(0, 9, 9, 1);
    end
    repeat (4) drive(0, 0, 0, 1);

    // Reset mid-vector, then a clean vector of (2,3).
    drive(1, 4, 4, 1);
    drive(1, 4, 4, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1, 2, 3, 1);
    repeat (4) drive(0, 0, 0, 1);

    // Random traffic with random gaps and back-pressure.
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 9) < 6);
    repeat (6) drive(0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
